// File: rtl/ram_reader_pkg.sv
// ============================================================================
// Module      : ram_reader_pkg
// Description : Shared types and constants for the RAM read-side initiator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_reader_pkg;

  // Address width of the 8 KB system RAM, shared with the RAM and decoder.
  localparam int RAM_ADDR_WIDTH = 13;

  // Reader control states; ST_CSUM is only reachable with checksum enabled.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_CSUM  = 2'd3
  } state_e;

  // Byte that brings the 8-bit sum of a stream back to zero.
  function automatic logic [7:0] csum_byte(input logic [7:0] sum);
    return 8'h00 - sum;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_reader_byte_fifo.sv
// ============================================================================
// Module      : byte_fifo
// Description : Small synchronous 8-bit FIFO with occupancy count. Storage is
//               not reset; only pointers and count are cleared.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign w_push_ok = push && (count_q != FULL_COUNT);
  assign w_pop_ok  = pop && (count_q != '0);

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign empty    = (count_q == '0);

  // Pointer and occupancy update; power-of-two depth lets pointers wrap freely.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (w_push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (w_pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + (PW+1)'(w_push_ok) - (PW+1)'(w_pop_ok);
  end

  // Pointer/count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Data storage write port.
  always_ff @(posedge clk) begin
    if (w_push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/ram_reader.sv
// ============================================================================
// Module      : ram_reader
// Description : Walks an address range of the system RAM through its
//               registered-read port and streams the bytes out on a
//               valid/ready interface. Reads are credit-limited against the
//               output FIFO so backpressure never loses data.
//               Optional: RAM_READER_CHECKSUM_EN appends a zero-sum byte.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_reader
  import ram_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_w_en,
  input  logic [7:0]            ram_dout,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
  logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
  logic                  inflight_q, inflight_d;
  logic                  done_q, done_d;
`ifdef RAM_READER_CHECKSUM_EN
  logic [7:0]            sum_q, sum_d;
`endif

  logic                  w_issue;
  logic                  w_push;
  logic [7:0]            w_push_data;
  logic                  w_pop;
  logic                  w_credit_ok;
  logic                  w_drained;
  logic [CW:0]           w_used;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_empty;
  logic [7:0]            fifo_head;

  // A read is outstanding from the cycle it is issued until its byte lands in
  // the FIFO, so credits count buffered bytes plus the one read in flight.
  assign w_used      = {1'b0, fifo_count} + (CW+1)'(inflight_q);
  assign w_credit_ok = (w_used < (CW+1)'(FIFO_DEPTH));
  assign w_pop       = tx_valid && tx_ready;
  // Empty after this edge: nothing arriving and the last buffered byte (if any) leaving.
  assign w_drained   = !inflight_q && (fifo_count == CW'(w_pop));

  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign ram_w_en    = 1'b0;
  assign ram_address = w_issue ? ptr_q : last_addr_q;
  assign tx_valid    = !fifo_empty;
  assign tx_data     = fifo_empty ? 8'h00 : fifo_head;
  assign inflight_d  = w_issue;

  // Next-state, issue control, counters and FIFO push selection.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    last_addr_d = last_addr_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    w_issue     = 1'b0;
    w_push      = inflight_q;
    w_push_data = ram_dout;
`ifdef RAM_READER_CHECKSUM_EN
    sum_d = inflight_q ? (sum_q + ram_dout) : sum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ptr_d       = start_addr;
          remaining_d = length;
`ifdef RAM_READER_CHECKSUM_EN
          sum_d       = 8'h00;
          state_d     = (length == '0) ? ST_CSUM : ST_ISSUE;
`else
          state_d     = (length == '0) ? ST_DRAIN : ST_ISSUE;
`endif
        end
      end
      ST_ISSUE: begin
        if (w_credit_ok) begin
          w_issue     = 1'b1;
          last_addr_d = ptr_q;
          ptr_d       = ptr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == (ADDR_WIDTH+1)'(1)) begin
`ifdef RAM_READER_CHECKSUM_EN
            state_d = ST_CSUM;
`else
            state_d = ST_DRAIN;
`endif
          end
        end
      end
`ifdef RAM_READER_CHECKSUM_EN
      ST_CSUM: begin
        // Wait until the last data byte has been summed and a slot is free.
        if (!inflight_q && (fifo_count < CW'(FIFO_DEPTH))) begin
          w_push      = 1'b1;
          w_push_data = csum_byte(sum_q);
          state_d     = ST_DRAIN;
        end
      end
`endif
      ST_DRAIN: begin
        if (w_drained) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers; reset abandons any transfer without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      last_addr_q <= '0;
      remaining_q <= '0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      last_addr_q <= last_addr_d;
      remaining_q <= remaining_d;
      inflight_q  <= inflight_d;
      done_q      <= done_d;
    end
  end

`ifdef RAM_READER_CHECKSUM_EN
  // Running sum of every data byte pushed in the current transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sum_q <= 8'h00;
    else     sum_q <= sum_d;
  end
`endif

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .pop_data  (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

endmodule

`default_nettype wire
